// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-access stage: load/store opcodes,
// pipeline constants and the bus transaction state encoding.
package mem_lsu_pkg;

    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [4:0]  NOPRegAddr = 5'b00000;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/mem_lsu_if.sv
// Data bus between the memory stage (master) and the data memory (slave):
// a registered request held until acknowledge.
interface mem_lsu_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
        output dbus_ack, dbus_rdata
    );
endinterface

// File: rtl/mem_lsu_lane.sv
// Byte-lane logic: decodes the memory opcode, produces big-endian byte
// enables and replicated store data, extracts/extends load data and
// flags misaligned halfword/word accesses. Purely combinational.
module lsu_lane
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] reg2,
    input  logic [31:0] rdata,
    output logic        is_mem,
    output logic        is_load,
    output logic        misalign,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Pick the addressed byte and halfword; offset 0 is the most significant lane.
    always_comb begin
        ld_byte = rdata[31:24];
        case (addr_lo)
            2'd0: ld_byte = rdata[31:24];
            2'd1: ld_byte = rdata[23:16];
            2'd2: ld_byte = rdata[15:8];
            2'd3: ld_byte = rdata[7:0];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    // Opcode decode into lane enables, store replication, load extension and alignment check.
    always_comb begin
        is_mem    = 1'b0;
        is_load   = 1'b0;
        misalign  = 1'b0;
        sel       = 4'b0000;
        wdata     = ZeroWord;
        load_data = ZeroWord;
        case (aluop)
            EXE_LB_OP, EXE_LBU_OP: begin
                is_mem    = 1'b1;
                is_load   = 1'b1;
                sel       = 4'b1000 >> addr_lo;
                load_data = (aluop == EXE_LB_OP) ? {{24{ld_byte[7]}}, ld_byte}
                                                 : {24'h000000, ld_byte};
            end
            EXE_LH_OP, EXE_LHU_OP: begin
                is_mem    = 1'b1;
                is_load   = 1'b1;
                misalign  = addr_lo[0];
                sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
                load_data = (aluop == EXE_LH_OP) ? {{16{ld_half[15]}}, ld_half}
                                                 : {16'h0000, ld_half};
            end
            EXE_LW_OP: begin
                is_mem    = 1'b1;
                is_load   = 1'b1;
                misalign  = (addr_lo != 2'b00);
                sel       = 4'b1111;
                load_data = rdata;
            end
            EXE_SB_OP: begin
                is_mem = 1'b1;
                sel    = 4'b1000 >> addr_lo;
                wdata  = {4{reg2[7:0]}};
            end
            EXE_SH_OP: begin
                is_mem   = 1'b1;
                misalign = addr_lo[0];
                sel      = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata    = {2{reg2[15:0]}};
            end
            EXE_SW_OP: begin
                is_mem   = 1'b1;
                misalign = (addr_lo != 2'b00);
                sel      = 4'b1111;
                wdata    = reg2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: passes ALU results through, runs load/store bus
// transactions with a stall until acknowledge, and aborts on timeout.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd_i,
    input  logic        mem_wreg_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [7:0]  mem_aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_reg2_i,
    mem_lsu_if.master   dbus,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        stallreq,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    lsu_state_e    state_q, state_n;
    logic [CW-1:0] cnt_q;
    logic [31:0]   cap_q;
    logic          abort_q;
    logic          issue;

    logic          is_mem, is_load, misalign;
    logic [3:0]    lane_sel;
    logic [31:0]   lane_wdata, load_data;

    lsu_lane u_lane (
        .aluop     (mem_aluop_i),
        .addr_lo   (mem_addr_i[1:0]),
        .reg2      (mem_reg2_i),
        .rdata     (cap_q),
        .is_mem    (is_mem),
        .is_load   (is_load),
        .misalign  (misalign),
        .sel       (lane_sel),
        .wdata     (lane_wdata),
        .load_data (load_data)
    );

    // State register; reset forces IDLE even in the middle of a transaction.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_n;
    end

    // Next state plus the combinational stall and write-back outputs.
    always_comb begin
        state_n    = state_q;
        issue      = 1'b0;
        stallreq   = 1'b0;
        misalign_o = 1'b0;
        bus_err_o  = 1'b0;
        wb_wd      = mem_wd_i;
        wb_wreg    = mem_wreg_i;
        wb_wdata   = mem_wdata_i;
        case (state_q)
            ST_IDLE: begin
                if (is_mem) begin
                    wb_wreg = 1'b0;
                    if (misalign) begin
                        misalign_o = 1'b1;
                    end else begin
                        stallreq = 1'b1;
                        issue    = 1'b1;
                        state_n  = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                stallreq = 1'b1;
                wb_wreg  = 1'b0;
                if (dbus.dbus_ack || cnt_q == LAST) state_n = ST_DONE;
            end
            ST_DONE: begin
                wb_wdata  = load_data;
                wb_wreg   = is_load & mem_wreg_i & ~abort_q;
                bus_err_o = abort_q;
                state_n   = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        if (rst) begin
            stallreq   = 1'b0;
            misalign_o = 1'b0;
            bus_err_o  = 1'b0;
            wb_wd      = NOPRegAddr;
            wb_wreg    = 1'b0;
            wb_wdata   = ZeroWord;
        end
    end

    // Bus request registers, BUSY cycle counter, read-data capture and abort flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbus.dbus_req   <= 1'b0;
            dbus.dbus_we    <= 1'b0;
            dbus.dbus_addr  <= ZeroWord;
            dbus.dbus_sel   <= 4'b0000;
            dbus.dbus_wdata <= ZeroWord;
            cnt_q           <= '0;
            cap_q           <= ZeroWord;
            abort_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (issue) begin
                        dbus.dbus_req   <= 1'b1;
                        dbus.dbus_we    <= ~is_load;
                        dbus.dbus_addr  <= {mem_addr_i[31:2], 2'b00};
                        dbus.dbus_sel   <= lane_sel;
                        dbus.dbus_wdata <= lane_wdata;
                        abort_q         <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (dbus.dbus_ack) begin
                        cap_q         <= dbus.dbus_rdata;
                        dbus.dbus_req <= 1'b0;
                    end else if (cnt_q == LAST) begin
                        dbus.dbus_req <= 1'b0;
                        abort_q       <= 1'b1;
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-access stage of the five-stage pipeline, placed directly after the EX/MEM latch and ahead of the MEM/WB latch. It passes non-memory results straight through. It turns load/store instructions into a registered request/acknowledge transaction on the data bus, stalling the pipeline until the bus acknowledges. It byte-lanes and sign/zero-extends load data, rejects misaligned accesses, and aborts transactions that exceed a timeout.

## Interface
Parameters:
- TIMEOUT, 16: maximum BUSY cycles without `dbus_ack` before abort (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- mem_wd_i  in  5  destination register from EX/MEM.
- mem_wreg_i  in  1  write-back enable from EX/MEM.
- mem_wdata_i  in  32  ALU result from EX/MEM.
- mem_aluop_i  in  8  operation code.
- mem_addr_i  in  32  effective byte address.
- mem_reg2_i  in  32  store data.
- dbus_req  out  1  request, registered.
- dbus_we  out  1  1 = write, registered.
- dbus_addr  out  32  word address, `{addr[31:2],2'b00}`, registered.
- dbus_sel  out  4  byte enables, big-endian, registered.
- dbus_wdata  out  32  lane-replicated store data, registered.
- dbus_ack  in  1  transaction complete.
- dbus_rdata  in  32  read data, valid with `dbus_ack`.
- wb_wd  out  5  to MEM/WB.
- wb_wreg  out  1  to MEM/WB.
- wb_wdata  out  32  to MEM/WB.
- stallreq  out  1  freeze request to pipeline control.
- misalign_o  out  1  misaligned access, one-cycle pulse.
- bus_err_o  out  1  timeout abort, one-cycle pulse.

## Operation
- Memory ops: LB, LBU, LH, LHU, LW, SB, SH, SW. Every other aluop passes through with zero latency: `wb_* = mem_*_i`, `stallreq = 0`.
- Misaligned access:
  - Condition: LH/LHU/SH with `addr[0] != 0`, or LW/SW with `addr[1:0] != 0`.
  - Response: no bus access, `wb_wreg = 0`, `misalign_o = 1`, `stallreq = 0`, FSM stays IDLE.
- Byte lanes (big-endian): byte offset 0 maps to `sel` 1000 and bits [31:24].
  - Halfword offset 0 → `sel` 1100; offset 2 → `sel` 0011.
  - Word → `sel` 1111.
- Store data: SB replicates `reg2[7:0]` ×4; SH replicates `reg2[15:0]` ×2; SW passes `reg2` unchanged.
- Loads: select the addressed lane from the captured read data. LB/LH sign-extend; LBU/LHU zero-extend. Stores force `wb_wreg = 0`.
- FSM states:
  - IDLE: on an aligned memory op, assert `stallreq` combinationally and register `dbus_req = 1` plus we/addr/sel/wdata. Next state BUSY.
  - BUSY: `stallreq = 1`; a cycle counter increments.
    - On `dbus_ack`: capture `dbus_rdata`, clear `dbus_req`, go to DONE.
    - When the counter reaches TIMEOUT without ack: clear `dbus_req`, set an abort flag, go to DONE.
  - DONE: `stallreq = 0`.
    - Outputs `wb_wd = mem_wd_i`, `wb_wdata` = extended load data.
    - `wb_wreg` follows load/store rules; it is forced to 0 on abort, and `bus_err_o = 1` on abort.
    - The EX/MEM latch advances at the end of DONE. Next state is always IDLE, which prevents re-issue of the same instruction.
- In IDLE and DONE, `dbus_ack` is ignored. A late ack after an abort is dropped.
- `dbus_*` outputs hold stable for the whole of BUSY.

## Timing
- Reset values: `dbus_req = 0`, `dbus_we = 0`, `dbus_addr = 0`, `dbus_sel = 0`, `dbus_wdata = 0`, state IDLE, counter 0, capture register 0, abort flag 0.
  - `wb_wd = 0`, `wb_wreg = 0`, `wb_wdata = 0`, `stallreq = 0`, `misalign_o = 0`, `bus_err_o = 0` while `rst` is high.
- Pass-through ops and misaligned ops have 0 cycles of added latency.
- Memory op with ack in the k-th BUSY cycle (k ≥ 1): `stallreq` is high for k+1 cycles and the result is presented in cycle k+2.
  - Minimum case: 2 stall cycles, 3 cycles total.
- Timeout: `stallreq` is high for TIMEOUT+1 cycles, then DONE with `bus_err_o`.
- Reset asserted mid-BUSY: at the next edge the FSM is IDLE, `dbus_req = 0` and the counter is cleared.
- Ack arriving in the same cycle as the TIMEOUT-th count: ack wins and there is no error.

## Structure
- The aluop codes (LB…SW), the NOPRegAddr/ZeroWord constants and the FSM state encodings belong in the shared defines header.
- Natural sub-module: `lsu_lane`. It is combinational and computes, from aluop and `addr[1:0]`, the sel, store data, load extraction/extension and the misalign flag.
- The FSM, counter and registers live in `mem_lsu`.

## Test plan
- OR result pass-through: `wdata = 0x00001234`, `wd = 5`, `wreg = 1` → same-cycle `wb` outputs match, `stallreq = 0`, no `dbus_req`.
- LB at addr 0x103 with `dbus_rdata = 0x000000F0`, ack in first BUSY cycle → `dbus_addr = 0x100`, `sel = 0001`, `wb_wdata = 0xFFFFFFF0`.
  - Same access as LBU → `wb_wdata = 0x000000F0`.
  - Both cases show 2 stall cycles.
- SH at addr 0x102 with `reg2 = 0x0000BEEF`, ack after 3 BUSY cycles → `we = 1`, `sel = 0011`, `wdata = 0xBEEFBEEF`, `stallreq` high 4 cycles, `wb_wreg = 0`.
- LW at addr 0x2 → `misalign_o = 1`, `wb_wreg = 0`, no `dbus_req`, `stallreq = 0`.
- LW with no ack → `dbus_req` high for 16 cycles, then DONE with `bus_err_o = 1` and `wb_wreg = 0`.
  - A late ack in the following IDLE cycle is ignored.
- `rst` pulsed in the 2nd BUSY cycle → next cycle `dbus_req = 0`, `stallreq = 0`, all outputs at their reset values.
